// File: rtl/uart_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bus_arbiter
//  Brief    : Two-master arbiter in front of a single shared UART peripheral
//             port. Round-robin on ties, one owner at a time, and a stall
//             watchdog that forces completion when the peripheral hangs.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,

  // requester 0 (CPU)
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  input  logic        m0_mem_write,
  input  logic        m0_mem_read,
  output logic [31:0] m0_read_data,
  output logic        m0_wait_request,

  // requester 1 (debug / DMA)
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  input  logic        m1_mem_write,
  input  logic        m1_mem_read,
  output logic [31:0] m1_read_data,
  output logic        m1_wait_request,

  // shared peripheral port
  output logic [31:0] s_address,
  output logic [31:0] s_write_data,
  output logic        s_mem_write,
  output logic        s_mem_read,
  input  logic [31:0] s_read_data,
  input  logic        s_wait_request,

  // status
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Counter is one bit wider than needed to hold TIMEOUT-1 so the
  // saturation guard below never has to fire in normal operation.
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  // last_owner = 1 means m1 was served last, so m0 wins the next tie
  logic             last_owner;
  logic             last_owner_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_nxt;

  logic        req0;
  logic        req1;
  logic        granted;
  logic        own_req;
  logic        own_rd;
  logic        own_wr;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [31:0] own_rdata;
  logic        stall_hit;
  logic        complete;
  logic        forced;
  logic        stalled;

  assign req0 = m0_mem_read | m0_mem_write;
  assign req1 = m1_mem_read | m1_mem_write;

  // Select the current owner's request fields and classify this grant cycle
  always_comb begin
    granted   = (state == ST_GNT0) || (state == ST_GNT1);
    own_req   = 1'b0;
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_addr  = 32'd0;
    own_wdata = 32'd0;
    if (state == ST_GNT0) begin
      own_req   = req0;
      own_rd    = m0_mem_read;
      own_wr    = m0_mem_write;
      own_addr  = m0_address;
      own_wdata = m0_write_data;
    end else if (state == ST_GNT1) begin
      own_req   = req1;
      own_rd    = m1_mem_read;
      own_wr    = m1_mem_write;
      own_addr  = m1_address;
      own_wdata = m1_write_data;
    end
    stall_hit = (stall_cnt == CNT_LAST);
    complete  = granted && own_req && !s_wait_request;
    forced    = granted && own_req &&  s_wait_request &&  stall_hit;
    stalled   = granted && own_req &&  s_wait_request && !stall_hit;
  end

  // Drive the peripheral port and the per-master responses
  always_comb begin
    s_address    = granted ? own_addr  : 32'd0;
    s_write_data = granted ? own_wdata : 32'd0;
    // strobes drop on a forced completion so the stuck access is abandoned
    s_mem_write  = granted && own_wr && !forced;
    s_mem_read   = granted && own_rd && !forced;
    timeout_err  = forced;

    own_rdata = 32'd0;
    if (complete && own_rd) begin
      own_rdata = s_read_data;
    end else if (forced && own_rd) begin
      own_rdata = ERR_DATA;
    end

    // a non-owner is stalled only while it is actually requesting
    m0_wait_request = (state == ST_GNT0) ? stalled   : req0;
    m1_wait_request = (state == ST_GNT1) ? stalled   : req1;
    m0_read_data    = (state == ST_GNT0) ? own_rdata : 32'd0;
    m1_read_data    = (state == ST_GNT1) ? own_rdata : 32'd0;

    grant = {(state == ST_GNT1), (state == ST_GNT0)};
  end

  // Next-state, round-robin pointer and stall counter logic
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    stall_cnt_nxt  = stall_cnt;
    case (state)
      ST_IDLE: begin
        // counter is cleared here, and GNT states are only entered from IDLE
        stall_cnt_nxt = '0;
        if (req0 && req1) begin
          state_nxt = last_owner ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
          state_nxt = ST_GNT0;
        end else if (req1) begin
          state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!own_req) begin
          // owner abandoned its request: release without touching the pointer
          state_nxt = ST_IDLE;
        end else if (complete || forced) begin
          state_nxt      = ST_IDLE;
          last_owner_nxt = (state == ST_GNT1);
        end else if (stall_cnt != CNT_MAX) begin
          stall_cnt_nxt = stall_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      stall_cnt  <= stall_cnt_nxt;
    end
  end

endmodule
`default_nettype wire
